module_display_7seg: RTL and testbench
======================================

Name: module_display_7seg

Overview:
- Display stage directly downstream of the operand/arithmetic datapath; consumes the binary result and drives a 4-digit multiplexed 7-segment display.
- On a load strobe, captures the binary value and converts it to BCD sequentially using double-dabble (one iteration per clock).
- Latches the BCD digits and time-multiplexes them onto common-anode digits, with leading-zero blanking and an overflow indication.

Parameters:
- WIDTH, 14, bit width of the binary input. The range 0..9999 fits; any value up to 2^WIDTH-1 is accepted.
- REFRESH_DIV, 27000, clk cycles each digit stays lit. Must be ≥2; benches use 4.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-low reset
- val  input  1  load strobe; bin is sampled on the clk edge where val=1 and the block is idle
- bin  input  WIDTH  unsigned binary value to display
- busy  output  1  high while a conversion is in progress
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}
- an  output  4  digit enables, active-low one-hot; an[0]=units, an[3]=thousands

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, busy=0, shift/BCD registers cleared, display register = 0, ovf=0.
  - Scan index=0, refresh counter=0.
  - Outputs while in reset: an=4'b1110, seg=7'b1000000 (digit "0").
- FSM states: IDLE and CONV.
- IDLE:
  - On an edge with val=1: load shift register ← bin, bcd ← 0, iter ← 0, ovf_pend ← (bin > 9999), state ← CONV, busy ← 1.
  - val=0: hold.
- CONV, one iteration per edge:
  - Each BCD nibble ≥5 gets +3 (combinationally).
  - Then {bcd, shift} shifts left by 1; iter increments.
  - On the WIDTH-th iteration edge: disp ← final BCD (16 bits, 4 nibbles), ovf ← ovf_pend, state ← IDLE, busy ← 0, all on the same edge.
- Latency: val sampled at edge k → busy=1 after edge k → new digits visible and busy=0 after edge k+WIDTH.
- val while busy=1 is ignored; there is no queueing, and the in-flight conversion completes unchanged.
- The display register holds its old value throughout CONV, so there are no partial results on the digits.
- Internal BCD accumulator is 4 nibbles. When ovf=1 its contents are don't-care and are not displayed.
- Scan:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously, independent of FSM state.
  - On wrap, the scan index advances 0→1→2→3→0.
  - an is driven low only on the bit for the current index; exactly one bit is low at all times out of reset.
- Segment decode for the selected digit (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- Leading-zero blanking:
  - Digit i>0 is blank (seg=1111111) if it and all higher digits are 0.
  - The units digit is never blanked, so value 0 shows "0".
- Overflow: when ovf=1, all four digits show a dash (seg=0111111) regardless of disp.
- Reset asserted mid-conversion: the conversion is aborted and all state returns to reset values. The previously displayed value is lost and the display shows "0".
- seg and an are registered or glitch-free combinational decode of registered state; both change only on the scan-index change edge or the disp update edge.

Test Plan:
- Reset check: hold rst=0 → busy=0, an=1110, seg=1000000. Release, with REFRESH_DIV=4 → an cycles 1110,1101,1011,0111 every 4 clks. Digits 1–3 show seg=1111111.
- Convert 1234:
  - val=1 for one cycle with bin=1234 → busy=1 for exactly 14 cycles, then 0.
  - Scan then shows an[0]:4 (0011001), an[1]:3 (0110000), an[2]:2 (0100100), an[3]:1 (1111001).
- Blanking: bin=7 → units 1111000, other three digits 1111111. bin=1000 → 1111111 never appears; zeros show 1000000.
- Overflow and boundary:
  - bin=9999 → four "9"s (0010000).
  - bin=10000 and bin=16383 → all digits 0111111.
  - Then bin=0 → units "0", others blank.
- Ignored strobe: bin=42 accepted, then val=1 with bin=99 at the 5th busy cycle → after completion the display shows 42 (2 on units, 4 on tens), and busy drops at the 14th cycle after the first load.
- Reset mid-operation: start conversion of 5678, assert rst at the 7th busy cycle → busy=0 immediately. After release, display shows "0" and an=1110. A fresh load of 5678 converts correctly.

Source files
------------

// File: rtl/module_display_7seg.sv
`default_nettype none
// ============================================================================
// Module      : module_display_7seg
// Description : Sequential double-dabble binary-to-BCD converter driving a
//               4-digit multiplexed common-anode 7-segment display.
// Revision    : 1.0 - initial release
// ============================================================================
module module_display_7seg #(
  parameter int WIDTH       = 14,
  parameter int REFRESH_DIV = 27000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             val,
  input  logic [WIDTH-1:0] bin,
  output logic             busy,
  output logic [6:0]       seg,
  output logic [3:0]       an
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;
  localparam int         IW     = $clog2(WIDTH + 1);
  localparam int         RW     = $clog2(REFRESH_DIV);

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [15:0]      bcd_q, bcd_d;
  logic [IW-1:0]    iter_q, iter_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      disp_q, disp_d;
  logic [RW-1:0]    rcnt_q, rcnt_d;
  logic [1:0]       scan_q, scan_d;

  logic [15:0]      bcd_adj;
  logic [15:0]      bcd_shf;
  logic [WIDTH-1:0] shift_shf;
  logic             last_iter;
  logic             load;

  for (genvar i = 0; i < 4; i++) begin : g_adj
    assign bcd_adj[4*i +: 4] = (bcd_q[4*i +: 4] >= 4'd5) ? bcd_q[4*i +: 4] + 4'd3
                                                          : bcd_q[4*i +: 4];
  end

  assign bcd_shf   = {bcd_adj[14:0], shift_q[WIDTH-1]};
  assign shift_shf = {shift_q[WIDTH-2:0], 1'b0};
  assign last_iter = (iter_q == IW'(WIDTH - 1));
  assign load      = (state_q == S_IDLE) && val;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (val) state_d = S_CONV;
      S_CONV:  if (last_iter) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CONV);
  end

  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    if (load) begin
      shift_d    = bin;
      bcd_d      = '0;
      iter_d     = '0;
      ovf_pend_d = ({{(32-WIDTH){1'b0}}, bin} > 32'd9999);
    end else if (state_q == S_CONV) begin
      shift_d = shift_shf;
      bcd_d   = bcd_shf;
      iter_d  = iter_q + IW'(1);
      // Display only changes once the full result is ready
      if (last_iter) begin
        disp_d = bcd_shf;
        ovf_d  = ovf_pend_q;
      end
    end
  end

  always_comb begin
    rcnt_d = rcnt_q + RW'(1);
    scan_d = scan_q;
    if (rcnt_q == RW'(REFRESH_DIV - 1)) begin
      rcnt_d = '0;
      scan_d = scan_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q    <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      disp_q     <= '0;
      rcnt_q     <= '0;
      scan_q     <= '0;
    end else begin
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
      disp_q     <= disp_d;
      rcnt_q     <= rcnt_d;
      scan_q     <= scan_d;
    end
  end

  logic [3:0] digit;
  logic       blank;
  logic [6:0] glyph;

  assign digit = disp_q[{scan_q, 2'b00} +: 4];

  // A digit is blank when it and every more significant digit are zero
  always_comb begin
    blank = 1'b0;
    case (scan_q)
      2'd1:    blank = (disp_q[15:4]  == 12'd0);
      2'd2:    blank = (disp_q[15:8]  == 8'd0);
      2'd3:    blank = (disp_q[15:12] == 4'd0);
      default: blank = 1'b0;
    endcase
  end

  always_comb begin
    case (digit)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1111000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b1111111;
    endcase
  end

  always_comb begin
    if (ovf_q)      seg = 7'b0111111;
    else if (blank) seg = 7'b1111111;
    else            seg = glyph;
    an = ~(4'b0001 << scan_q);
  end

endmodule
`default_nettype wire

// File: tb/tb_module_display_7seg.sv
`default_nettype none
// ============================================================================
// Module      : tb_module_display_7seg
// Description : Scoreboard bench for module_display_7seg with random loads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_module_display_7seg;

  localparam int WIDTH = 14;
  localparam int RD    = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             val = 1'b0;
  logic [WIDTH-1:0] bin = '0;
  logic             busy;
  logic [6:0]       seg;
  logic [3:0]       an;

  module_display_7seg #(.WIDTH(WIDTH), .REFRESH_DIV(RD)) dut (
    .clk  (clk),
    .rst  (rst),
    .val  (val),
    .bin  (bin),
    .busy (busy),
    .seg  (seg),
    .an   (an)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal digits from plain arithmetic, then glyph lookup
  function automatic logic [6:0] exp_seg(input int v, input int i);
    int pw;
    int d;
    logic [6:0] tbl [10];
    tbl = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
    if (v > 9999) return 7'b0111111;
    pw = 1;
    for (int k = 0; k < i; k++) pw = pw * 10;
    if (i > 0 && v < pw) return 7'b1111111;
    d = (v / pw) % 10;
    return tbl[d];
  endfunction

  // Scoreboard: values whose conversion result is still owed by the DUT
  int q[$];
  int cur_exp   = 0;
  int busy_cnt  = 0;
  bit prev_busy = 1'b0;
  int edges_n   = 0;

  always @(posedge clk) begin
    if (!rst) edges_n = 0;
    else      edges_n++;
  end

  always @(negedge clk) begin
    int idx;
    if (!rst) begin
      q.delete();
      cur_exp  = 0;
      busy_cnt = 0;
      check("rst_busy", {31'd0, busy}, 32'd0);
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        busy_cnt++;
      end else if (prev_busy) begin
        check("busy_len", busy_cnt, WIDTH);
        if (q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: actual completion required none at %0t", $time);
        end else begin
          cur_exp = q.pop_front();
        end
        busy_cnt = 0;
      end
      prev_busy = busy;
    end
    idx = (edges_n / RD) % 4;
    check("an", {28'd0, an}, {28'd0, ~(4'b0001 << idx)});
    check($sformatf("seg[v=%0d,d=%0d]", cur_exp, idx), {25'd0, seg},
          {25'd0, exp_seg(cur_exp, idx)});
  end

  task automatic settle();
    repeat (4 * RD + 2) @(negedge clk);
  endtask

  // Issue one load; optionally strobe val again at busy cycle ign_at or
  // assert reset at busy cycle rst_at.
  task automatic do_load(input int v, input int ign_at, input int ign_v, input int rst_at);
    int  c;
    bit  aborted;
    c = 0;
    while (busy && c < 40) begin
      @(negedge clk);
      c++;
    end
    if (busy) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_wait: actual busy required idle at %0t", $time);
    end
    val = 1'b1;
    bin = WIDTH'(v);
    q.push_back(v);
    @(negedge clk);
    val = 1'b0;
    check("busy_rise", {31'd0, busy}, 32'd1);
    c = 1;
    aborted = 1'b0;
    while (busy && c <= WIDTH + 4) begin
      if (c == ign_at) begin
        val = 1'b1;
        bin = WIDTH'(ign_v);
      end else begin
        val = 1'b0;
      end
      if (c == rst_at) begin
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_an", {28'd0, an}, 32'b1110);
        check("midrst_seg", {25'd0, seg}, 32'b1000000);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        aborted = 1'b1;
        break;
      end
      @(negedge clk);
      c++;
    end
    val = 1'b0;
    if (!aborted && c > WIDTH + 4) begin
      n_checks++;
      n_fail++;
      $display("FAIL busy_timeout: actual busy required idle at %0t", $time);
    end
    settle();
  endtask

  initial begin
    int dir [7];
    dir = '{1234, 7, 1000, 9999, 10000, 16383, 0};
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    settle();
    foreach (dir[i]) do_load(dir[i], 0, 0, 0);
    do_load(42, 5, 99, 0);
    do_load(5678, 0, 0, 7);
    do_load(5678, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      int v;
      v = (i % 3 == 0) ? int'($urandom_range(0, 16383)) : int'($urandom_range(0, 9999));
      if (i % 4 == 0)
        do_load(v, int'($urandom_range(1, WIDTH)), int'($urandom_range(0, 16383)), 0);
      else
        do_load(v, 0, 0, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
